instr_fetch_buffer: RTL

- Small instruction queue between the fetch stage (PC register + instruction memory) and decode.
- Captures {pc, instr} pairs from fetch and presents them to decode with valid/ready handshakes on both sides.
- Absorbs decode stalls without stopping fetch immediately.
- Discards all buffered instructions on a control-flow redirect (flush).

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_buf_mem.sv | 26 ++
 rtl/instr_fetch_buffer.sv | 90 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-path types and constants
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_buf_mem.sv
// rtl/fetch_buf_mem.sv - DEPTH x {pc, instr} register array, one write port, one async read port
module fetch_buf_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [2*XLEN-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [2*XLEN-1:0] rdata
);

  fetch_pair_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= fetch_pair_t'(wdata);
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - fetch-to-decode FIFO with flush; FETCH_BUF_BYPASS_EN enables empty-buffer bypass
module instr_fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [2*XLEN-1:0] rdata;
  fetch_pair_t       head;
  logic              empty;
  logic              bypass;
  logic              push;
  logic              wr_en;
  logic              pop_mem;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = (!empty && !flush) || bypass;
  assign head      = bypass ? fetch_pair_t'({in_pc, in_instr}) : fetch_pair_t'(rdata);
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : NOP_INSTR;

  // A bypassed pair taken by decode in the same cycle never touches storage.
  assign push    = in_valid && in_ready;
  assign wr_en   = push && !flush && !(bypass && out_ready);
  assign pop_mem = out_valid && out_ready && !empty;

  fetch_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_mem) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop_mem})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
